// File: rtl/nrisc_ula_mul_seq.sv
// nrisc_ula_mul_seq: multicycle unsigned shift-and-add multiplier that owns the
// single NRISC_ULA instance. When idle, core operands pass straight through to
// the ULA. A multiply request takes the ULA over for a sequence of add,
// shift-left and shift-right steps. The low TAM bits of the product are then
// registered and reported with a one-cycle done pulse.
module nrisc_ula_mul_seq #(
    parameter int TAM = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           MUL_start,
    input  logic [TAM-1:0] MUL_A,
    input  logic [TAM-1:0] MUL_B,
    output logic           MUL_busy,
    output logic           MUL_done,
    output logic [TAM-1:0] MUL_result,
    input  logic [TAM-1:0] CORE_A,
    input  logic [TAM-1:0] CORE_B,
    input  logic [3:0]     CORE_ctrl,
    output logic           CORE_stall,
    output logic [TAM-1:0] ULA_A_o,
    output logic [TAM-1:0] ULA_B_o,
    output logic [3:0]     ULA_ctrl_o,
    input  logic [TAM-1:0] ULA_OUT_i,
    input  logic [2:0]     ULA_flags_i
);

    localparam logic [3:0] ULA_ADD = 4'b0000;
    localparam logic [3:0] ULA_SHL = 4'b1100;
    localparam logic [3:0] ULA_SHR = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [TAM-1:0] acc, mc, mp;

    // Only the zero flag steers the sequence; minus and carry are don't-care.
    logic flags_unused;
    assign flags_unused = ULA_flags_i[2] ^ ULA_flags_i[0];

    // State register with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: walk the multiplier one bit per add/shift round and stop
    // once the right-shifted multiplier has become zero.
    // NOTE: state_nxt gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (MUL_start) begin
                    if (MUL_B == '0)  state_nxt = S_DONE;
                    else if (MUL_B[0]) state_nxt = S_ADD;
                    else               state_nxt = S_SHL;
                end
            end
            S_ADD: state_nxt = S_SHL;
            S_SHL: state_nxt = S_SHR;
            S_SHR: begin
                if (ULA_flags_i[1])    state_nxt = S_DONE;
                else if (ULA_OUT_i[0]) state_nxt = S_ADD;
                else                   state_nxt = S_SHL;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: ULA steering per state plus busy/done/stall decode.
    always_comb begin
        ULA_A_o    = '0;
        ULA_B_o    = '0;
        ULA_ctrl_o = ULA_ADD;
        case (state)
            S_IDLE: begin
                ULA_A_o    = CORE_A;
                ULA_B_o    = CORE_B;
                ULA_ctrl_o = CORE_ctrl;
            end
            S_ADD: begin
                ULA_A_o    = acc;
                ULA_B_o    = mc;
                ULA_ctrl_o = ULA_ADD;
            end
            S_SHL: begin
                ULA_A_o    = mc;
                ULA_B_o    = TAM'(1);
                ULA_ctrl_o = ULA_SHL;
            end
            S_SHR: begin
                ULA_A_o    = mp;
                ULA_B_o    = TAM'(1);
                ULA_ctrl_o = ULA_SHR;
            end
            default: begin
                ULA_A_o    = '0;
                ULA_B_o    = '0;
                ULA_ctrl_o = ULA_ADD;
            end
        endcase
        MUL_busy   = (state != S_IDLE);
        MUL_done   = (state == S_DONE);
        CORE_stall = (state != S_IDLE);
    end

    // Datapath registers: load operands on start, capture each state's ULA
    // result at its closing edge, and latch the product when entering DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc        <= '0;
            mc         <= '0;
            mp         <= '0;
            MUL_result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MUL_start) begin
                        acc <= '0;
                        mc  <= MUL_A;
                        mp  <= MUL_B;
                    end
                end
                S_ADD:   acc <= ULA_OUT_i;
                S_SHL:   mc  <= ULA_OUT_i;
                S_SHR:   mp  <= ULA_OUT_i;
                default: ;
            endcase
            // A zero multiplier skips straight to DONE with an empty product;
            // the stale acc from a previous operation must not leak out.
            if (state_nxt == S_DONE && state != S_DONE)
                MUL_result <= (state == S_IDLE) ? '0 : acc;
        end
    end

endmodule
